// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/memory result inputs, register-file write port, hazard query.
// Optional WB_FWD_EN adds the forwarding query/response signals.
interface wb_arbiter_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 4,
    parameter int CNT_W    = $clog2(LQ_DEPTH) + 1
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              busy;
    logic [CNT_W-1:0]  lq_count;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_hit;
`ifdef WB_FWD_EN
    logic [ADDR_W-1:0] fwd_addr1;
    logic [ADDR_W-1:0] fwd_addr2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
`endif

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        output wrEn, wrAddr, wrData,
        output busy, lq_count,
        input  pend_addr,
        output pend_hit
`ifdef WB_FWD_EN
        , input  fwd_addr1, fwd_addr2
        , output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        input  wrEn, wrAddr, wrData,
        input  busy, lq_count,
        output pend_addr,
        input  pend_hit
`ifdef WB_FWD_EN
        , output fwd_addr1, fwd_addr2
        , input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, long-latency results wait in a FIFO.
// Optional macro WB_FWD_EN adds combinational forwarding of the in-flight output write.
module wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 4,
    parameter int CNT_W    = $clog2(LQ_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int                PTR_W     = $clog2(LQ_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(LQ_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [ADDR_W-1:0] lq_addr_r [LQ_DEPTH];
    logic [DATA_W-1:0] lq_data_r [LQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;

    logic mem_ready_s;
    logic alu_sel_s;
    logic enq_s;
    logic deq_s;
    logic lq_hit_s;
    logic pend_hit_s;

    // An entry is live when its distance from the read pointer is below the occupancy.
    function automatic logic entry_live(input logic [PTR_W-1:0] idx,
                                        input logic [PTR_W-1:0] rd,
                                        input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] offset;
        offset = idx - rd;
        return ({1'b0, offset} < cnt);
    endfunction

    assign mem_ready_s = (count_r < DEPTH_C) && !rst;
    assign alu_sel_s   = bus.alu_valid && (bus.alu_addr != ADDR_ZERO);
    // Writes to r0 complete the handshake but are never stored.
    assign enq_s       = bus.mem_valid && mem_ready_s && (bus.mem_addr != ADDR_ZERO);
    assign deq_s       = !alu_sel_s && (count_r != CNT_ZERO);

    // Load-queue storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_addr_r[i] <= ADDR_ZERO;
                lq_data_r[i] <= DATA_ZERO;
            end
        end else if (enq_s) begin
            lq_addr_r[wr_ptr_r] <= bus.mem_addr;
            lq_data_r[wr_ptr_r] <= bus.mem_data;
        end
    end

    // Queue pointers and occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Register-file write port: ALU first, then queue head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= ADDR_ZERO;
            wr_data_r <= DATA_ZERO;
        end else if (alu_sel_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= bus.alu_addr;
            wr_data_r <= bus.alu_data;
        end else if (deq_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= lq_addr_r[rd_ptr_r];
            wr_data_r <= lq_data_r[rd_ptr_r];
        end else begin
            wr_en_r   <= 1'b0;
        end
    end

    // Hazard lookup across all live queue entries
    always_comb begin
        lq_hit_s = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            lq_hit_s = lq_hit_s |
                       (entry_live(PTR_W'(i), rd_ptr_r, count_r) && (lq_addr_r[i] == bus.pend_addr));
        end
    end

    assign pend_hit_s = (bus.pend_addr != ADDR_ZERO) &&
                        (lq_hit_s || (wr_en_r && (wr_addr_r == bus.pend_addr)));

    assign bus.mem_ready = mem_ready_s;
    assign bus.wrEn      = wr_en_r;
    assign bus.wrAddr    = wr_addr_r;
    assign bus.wrData    = wr_data_r;
    assign bus.busy      = (count_r != CNT_ZERO) || wr_en_r;
    assign bus.lq_count  = count_r;
    assign bus.pend_hit  = pend_hit_s;

`ifdef WB_FWD_EN
    // Covers the cycle where the register file has not yet absorbed the write.
    assign bus.fwd_hit1  = wr_en_r && (wr_addr_r == bus.fwd_addr1) && (bus.fwd_addr1 != ADDR_ZERO);
    assign bus.fwd_hit2  = wr_en_r && (wr_addr_r == bus.fwd_addr2) && (bus.fwd_addr2 != ADDR_ZERO);
    assign bus.fwd_data1 = bus.fwd_hit1 ? wr_data_r : DATA_ZERO;
    assign bus.fwd_data2 = bus.fwd_hit2 ? wr_data_r : DATA_ZERO;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, multi-cycle sequences, and random traffic
// checked against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .LQ_DEPTH(DEPTH), .CNT_W(CW)) bus ();

    wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LQ_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic [AW-1:0] pa;
        logic          e_en;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cnt;
        logic          e_rdy;
        logic          e_hit;
    } vec_t;

    // Reference model: a plain FIFO of pending writes plus the last register-file write.
    ent_t          mq[$];
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_edge();
        ent_t e;
        bit   hs;
        hs = bus.mem_valid && (mq.size() < DEPTH);
        if (bus.alu_valid && bus.alu_addr != 0) begin
            m_en = 1'b1; m_addr = bus.alu_addr; m_data = bus.alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_en = 1'b1; m_addr = e.addr; m_data = e.data;
        end else begin
            m_en = 1'b0;
        end
        if (hs && bus.mem_addr != 0) begin
            e.addr = bus.mem_addr; e.data = bus.mem_data;
            mq.push_back(e);
        end
    endtask

    function automatic logic model_hit(input logic [AW-1:0] pa);
        logic h;
        h = m_en && (m_addr == pa);
        foreach (mq[i]) h = h || (mq[i].addr == pa);
        return (pa != 0) && h;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".wrEn"},     bus.wrEn,     m_en);
        check({tag, ".wrAddr"},   bus.wrAddr,   m_addr);
        check({tag, ".wrData"},   bus.wrData,   m_data);
        check({tag, ".lq_count"}, bus.lq_count, mq.size());
        check({tag, ".mem_ready"}, bus.mem_ready, !rst && (mq.size() < DEPTH));
        check({tag, ".busy"},     bus.busy,     (mq.size() != 0) || m_en);
        check({tag, ".pend_hit"}, bus.pend_hit, model_hit(bus.pend_addr));
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                         input logic [AW-1:0] pa);
        @(negedge clk);
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.pend_addr = pa;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t vecs[$];
    int   retired;

    initial begin
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.pend_addr = '0;
`ifdef WB_FWD_EN
        bus.fwd_addr1 = '0; bus.fwd_addr2 = '0;
`endif
        model_reset();

        //             av    aa     ad            mv    ma     md       pa     en    addr   data          cnt   rdy   hit
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd0,  1'b0, 5'd0,  32'd0,        3'd0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 5'd7, 32'd100,      1'b1, 5'd1, 32'd10, 5'd3,  1'b1, 5'd7,  32'd100,      3'd1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 5'd7, 32'd101,      1'b1, 5'd2, 32'd11, 5'd3,  1'b1, 5'd7,  32'd101,      3'd2, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 5'd7, 32'd102,      1'b1, 5'd3, 32'd12, 5'd3,  1'b1, 5'd7,  32'd102,      3'd3, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 5'd7, 32'd103,      1'b1, 5'd4, 32'd13, 5'd3,  1'b1, 5'd7,  32'd103,      3'd4, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 5'd7, 32'd104,      1'b1, 5'd5, 32'd14, 5'd3,  1'b1, 5'd7,  32'd104,      3'd4, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd3,  1'b1, 5'd1,  32'd10,       3'd3, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd3,  1'b1, 5'd2,  32'd11,       3'd2, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd3,  1'b1, 5'd3,  32'd12,       3'd1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd3,  1'b1, 5'd4,  32'd13,       3'd0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd4,  1'b0, 5'd4,  32'd13,       3'd0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 5'd0, 32'd66,       1'b1, 5'd0, 32'd55, 5'd0,  1'b0, 5'd4,  32'd13,       3'd0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd0,  1'b0, 5'd4,  32'd13,       3'd0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 5'd0, 32'd70,       1'b1, 5'd9, 32'd90, 5'd9,  1'b0, 5'd4,  32'd13,       3'd1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 5'd0, 32'd77,       1'b0, 5'd0, 32'd0,  5'd9,  1'b1, 5'd9,  32'd90,       3'd0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b1, 5'd8, 32'd80,       1'b1, 5'd6, 32'd60, 5'd6,  1'b1, 5'd8,  32'd80,       3'd1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b1, 5'd11, 32'd61, 5'd11, 1'b1, 5'd6, 32'd60,       3'd1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd11, 1'b1, 5'd11, 32'd61,       3'd0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,  5'd11, 1'b0, 5'd11, 32'd61,       3'd0, 1'b1, 1'b0});

        // Values while reset is held, then right after release.
        repeat (2) @(posedge clk);
        #1;
        check("rst.mem_ready", bus.mem_ready, 1'b0);
        check("rst.wrEn",      bus.wrEn,      1'b0);
        check("rst.lq_count",  bus.lq_count,  3'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.mem_ready", bus.mem_ready, 1'b1);
        check("rel.wrAddr",    bus.wrAddr,    5'd0);
        check("rel.wrData",    bus.wrData,    32'd0);
        check("rel.busy",      bus.busy,      1'b0);
        check("rel.pend_hit",  bus.pend_hit,  1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].pa);
            tick();
            check($sformatf("vec%0d.wrEn", i),      bus.wrEn,      vecs[i].e_en);
            check($sformatf("vec%0d.wrAddr", i),    bus.wrAddr,    vecs[i].e_addr);
            check($sformatf("vec%0d.wrData", i),    bus.wrData,    vecs[i].e_data);
            check($sformatf("vec%0d.lq_count", i),  bus.lq_count,  vecs[i].e_cnt);
            check($sformatf("vec%0d.mem_ready", i), bus.mem_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d.pend_hit", i),  bus.pend_hit,  vecs[i].e_hit);
        end

        // Reset while the queue is draining: everything in flight is discarded.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd7, 32'd200 + k, 1'b1, AW'(k + 1), 32'd21 + k, 5'd2);
            tick();
            compare_model($sformatf("fill%0d", k));
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2);
        tick();
        compare_model("drain0");
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst.wrEn",      bus.wrEn,      1'b0);
        check("midrst.wrAddr",    bus.wrAddr,    5'd0);
        check("midrst.wrData",    bus.wrData,    32'd0);
        check("midrst.lq_count",  bus.lq_count,  3'd0);
        check("midrst.mem_ready", bus.mem_ready, 1'b0);
        check("midrst.busy",      bus.busy,      1'b0);
        check("midrst.pend_hit",  bus.pend_hit,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2);
            tick();
            check($sformatf("postrst%0d.wrEn", k), bus.wrEn, 1'b0);
            compare_model($sformatf("postrst%0d", k));
        end

        // Wrap: two primed entries, then ten enqueue/dequeue pairs, then drain.
        retired = 0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 5'd7, 32'd300 + k, 1'b1, AW'(8 + k), 32'd1000 + k, 5'd0);
            tick();
            compare_model($sformatf("prime%0d", k));
        end
        for (int k = 0; k < 13; k++) begin
            if (k < 10) drive(1'b0, 5'd0, 32'd0, 1'b1, AW'(10 + k), 32'd1002 + k, AW'(10 + k));
            else        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
            tick();
            compare_model($sformatf("wrap%0d", k));
            check($sformatf("wrap%0d.bound", k), bus.lq_count <= 3'd4, 1'b1);
            if (bus.wrEn && bus.wrAddr >= 5'd8) retired++;
        end
        check("wrap.retired", retired, 12);

        // Random traffic in phases of light, medium and heavy ALU load.
        for (int c = 0; c < 600; c++) begin
            int pct;
            logic [AW-1:0] ma;
            pct = ((c / 100) % 3 == 0) ? 10 : (((c / 100) % 3 == 1) ? 50 : 95);
            ma  = AW'($urandom_range(0, 7));
            drive($urandom_range(0, 99) < pct, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 60, ma, $urandom, AW'($urandom_range(0, 7)));
            tick();
            compare_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file.
- Merges two result sources into the register file's single write port:
  - the single-cycle ALU (strict priority, no backpressure);
  - the long-latency memory/multiply unit (valid/ready handshake, buffered in a FIFO load queue).
- Drives registered wrEn/wrAddr/wrData, and exposes a pending-write query so decode can stall on write-after-write and read-after-write hazards.

Parameters:
- DATA_W, 32, data width of a writeback
- ADDR_W, 5, register address width
- LQ_DEPTH, 4, load-queue entries; power of two, >= 2
- CNT_W, $clog2(LQ_DEPTH)+1, width of lq_count

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result valid this cycle; always accepted
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  long-latency result offered
- mem_ready  out  1  queue can accept; transfer when mem_valid && mem_ready
- mem_addr  in  ADDR_W  long-latency destination register
- mem_data  in  DATA_W  long-latency result
- wrEn  out  1  register file write enable
- wrAddr  out  ADDR_W  register file write address
- wrData  out  DATA_W  register file write data
- busy  out  1  queue non-empty or wrEn high
- lq_count  out  CNT_W  queue occupancy, 0..LQ_DEPTH
- pend_addr  in  ADDR_W  hazard query address
- pend_hit  out  1  pend_addr != 0 and it matches a valid queue entry or (wrEn && wrAddr)

Behaviour:
- Reset, asynchronous, while rst high:
  - wrEn=0, wrAddr=0, wrData=0, lq_count=0, busy=0, pend_hit=0.
  - Read/write pointers cleared; mem_ready forced 0.
  - mem_ready=1 from the first cycle after release.
- Reset mid-operation: all queued entries and any pending output write are discarded; nothing is written after reset.
- Enqueue:
  - mem_ready = (lq_count < LQ_DEPTH) && !rst, combinational from registered count only.
  - Never 1 when full, even if a dequeue happens in the same cycle.
  - A handshake with mem_addr==0 is accepted but not stored: no entry, lq_count unchanged.
- Selection each cycle, registered at the next edge:
  - 1) alu_valid && alu_addr!=0: wrEn<=1, wrAddr<=alu_addr, wrData<=alu_data. Queue not popped.
  - 2) else if the queue is non-empty: pop the head; wrEn<=1 with the head's addr/data.
  - 3) else wrEn<=0; wrAddr/wrData hold their previous values.
  - alu_valid with alu_addr==0 is dropped and counts as no ALU request, so the queue may drain that cycle.
- Latency:
  - ALU result to wrEn: 1 cycle.
  - Memory handshake at edge N: entry becomes visible in cycle N+1 and earliest wrEn is after edge N+1 (minimum 2 cycles).
- Simultaneous enqueue and dequeue (not full): lq_count unchanged, pointers both advance.
- Pointers wrap modulo LQ_DEPTH. lq_count is an explicit counter; full/empty are derived from the count, not from pointer equality.
- Ordering:
  - Queue entries retire strictly FIFO.
  - ALU-vs-queue order to the same register is not guaranteed. Decode must stall on pend_hit before issuing an ALU op whose destination matches.
- Starvation: continuous ALU traffic starves the queue indefinitely. The pipeline controller uses busy/lq_count to insert bubbles.
- pend_hit is combinational over all valid entries plus the output register; address 0 never hits.

Optional Feature:
- Macro: WB_FWD_EN
- Defined: adds ports fwd_addr1/fwd_addr2 (in, ADDR_W), fwd_hit1/fwd_hit2 (out, 1), fwd_data1/fwd_data2 (out, DATA_W).
  - fwd_hitK = wrEn && wrAddr==fwd_addrK && fwd_addrK!=0.
  - fwd_dataK = wrData when hit, else 0.
  - Purely combinational; covers the cycle in which the register file write has not yet landed.
- Undefined: these ports and their logic do not exist.

Test Plan:
- Reset release, idle -> wrEn=0, wrAddr=0, wrData=0, lq_count=0, mem_ready=1, busy=0.
- alu_valid=1, alu_addr=5, alu_data=32'hDEADBEEF for one cycle -> next cycle wrEn=1, wrAddr=5, wrData=32'hDEADBEEF; following cycle wrEn=0, wrAddr still 5.
- 4 memory handshakes (addrs 1..4, data 10..13) while alu_valid=1 with addr 7 every cycle:
  - lq_count reaches 4, mem_ready=0, pend_addr=3 gives pend_hit=1.
  - Drop alu_valid -> writes to 1,2,3,4 with data 10..13 on consecutive cycles; lq_count returns to 0.
- mem handshake with addr 0 and alu_valid with addr 0 -> no wrEn, lq_count stays 0, pend_addr=0 gives pend_hit=0.
- Queue holding 2 entries, assert rst mid-drain for 1 cycle -> outputs cleared immediately, no further wrEn, lq_count=0.
- Queue wrap test: 10 back-to-back enqueue/dequeue pairs at depth 4 -> data retires in exact order, lq_count never exceeds 4, no write lost.
